// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- writeback buffer between the memory stage and the register file.
//
// Each accepted entry is fully resolved on entry: the result is picked from the
// ALU result, the PC+4 link value, or an extracted and extended load field.
// Entries sit in a DEPTH-deep circular FIFO and drain one per clock, unless
// stalled, into a registered register-file write port. Entries that do not
// write (rd = x0, or "no writeback") are still consumed, but rf_we stays low
// for them.
//
// Optional feature: define WB_FWD_EN to add a combinational forwarding port
// that exposes the youngest buffered entry for decode-stage hazard bypass.
// Without the macro the ports and their logic are not built.
//
// Parameters
//   DEPTH       buffer depth in entries: 2, 4 or 8
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active low
//   in_valid    upstream entry valid
//   in_ready    buffer can accept (count < DEPTH); held low while in reset
//   in_wb_sel   result source: 00 ALU, 01 MEM, 10 PC+4, 11 none
//   in_rd       destination register
//   in_alu      ALU result
//   in_pc       instruction PC
//   in_mem      raw memory word
//   in_ld_op    load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, else LW
//   in_addr_lo  low two bits of the load address
//   stall       freezes draining; pushes still accepted while not full
//   rf_we       register-file write enable (registered)
//   rf_wR       register-file write address (registered)
//   rf_wD       register-file write data (registered)
//   fwd_valid   [WB_FWD_EN] youngest buffered entry writes a register
//   fwd_rd      [WB_FWD_EN] its destination register, 0 when invalid
//   fwd_data    [WB_FWD_EN] its resolved data, 0 when invalid
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_wb_sel,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_mem,
  input  logic [2:0]  in_ld_op,
  input  logic [1:0]  in_addr_lo,
  input  logic        stall,
  output logic        rf_we,
  output logic [4:0]  rf_wR,
  output logic [31:0] rf_wD
`ifdef WB_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
`endif
);

  // DEPTH is a power of two, so the pointers wrap modulo DEPTH for free.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_PC4  = 2'b10,
    WB_NONE = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } ld_op_e;

  // ---------------------------------------------------------------------------
  // Buffer state
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [4:0]       r_rd_mem   [DEPTH];
  logic [31:0]      r_data_mem [DEPTH];
  logic             r_we_mem   [DEPTH];

  // ---------------------------------------------------------------------------
  // Push-side result resolution
  // ---------------------------------------------------------------------------
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_push_data;
  logic        w_push_we;

  // NOTE: every signal driven here gets a default first, so no path through the
  // case statements can leave a value unassigned and infer a latch.
  always_comb begin
    w_byte = in_mem[7:0];
    case (in_addr_lo)
      2'd1:    w_byte = in_mem[15:8];
      2'd2:    w_byte = in_mem[23:16];
      2'd3:    w_byte = in_mem[31:24];
      default: w_byte = in_mem[7:0];
    endcase

    // Halfword loads pick by address bit 1 only; bit 0 is ignored.
    w_half = in_addr_lo[1] ? in_mem[31:16] : in_mem[15:0];

    w_load = in_mem;
    case (in_ld_op)
      LD_LB:   w_load = {{24{w_byte[7]}}, w_byte};
      LD_LH:   w_load = {{16{w_half[15]}}, w_half};
      LD_LBU:  w_load = {24'h0, w_byte};
      LD_LHU:  w_load = {16'h0, w_half};
      LD_LW:   w_load = in_mem;
      default: w_load = in_mem;   // reserved codes behave as LW
    endcase

    w_push_data = 32'h0;
    case (in_wb_sel)
      WB_ALU:  w_push_data = in_alu;
      WB_MEM:  w_push_data = w_load;
      WB_PC4:  w_push_data = in_pc + 32'd4;   // wraps modulo 2^32
      default: w_push_data = 32'h0;           // no writeback: data unused
    endcase

    // Writes to x0 and "no writeback" entries are kept in the FIFO so they
    // retire in order, but never raise rf_we.
    w_push_we = (in_rd != 5'd0) && (in_wb_sel != WB_NONE);
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic w_not_full;
  logic w_push;
  logic w_pop;

  // A full buffer never accepts, even if it pops on the same edge: the ready
  // path does not depend on stall or on the pop decision.
  assign w_not_full = (r_count < CNT_W'(DEPTH));
  assign in_ready   = rst & w_not_full;
  assign w_push     = in_valid & in_ready;
  assign w_pop      = ~stall & (r_count != '0);

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; validity comes entirely from r_count,
  // so stale contents are never observed and the array maps to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_mem[r_tail]   <= in_rd;
      r_data_mem[r_tail] <= w_push_data;
      r_we_mem[r_tail]   <= w_push_we;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy and the registered register-file port
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every update sees the
  // pre-edge values of r_head/r_tail/r_count, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      rf_we   <= 1'b0;
      rf_wR   <= 5'd0;
      rf_wD   <= 32'h0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;   // idle, or push and pop together
      endcase

      // Only a pop can raise rf_we; address and data hold between pops.
      rf_we <= w_pop & r_we_mem[r_head];
      if (w_pop) begin
        rf_wR <= r_rd_mem[r_head];
        rf_wD <= r_data_mem[r_head];
      end
    end
  end

`ifdef WB_FWD_EN
  // ---------------------------------------------------------------------------
  // Forwarding of the youngest buffered entry (the one just behind the tail)
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] w_young;

  assign w_young   = r_tail - PTR_W'(1);
  assign fwd_valid = (r_count != '0) && r_we_mem[w_young];
  assign fwd_rd    = fwd_valid ? r_rd_mem[w_young]   : 5'd0;
  assign fwd_data  = fwd_valid ? r_data_mem[w_young] : 32'h0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage (DEPTH = 4).
//
// A table of single-entry vectors carries inputs and expected RF results; a
// monitor keeps a queue of expected entries, pushed whenever an entry is
// accepted and popped whenever the buffer should drain, and compares the RF
// port after every edge. Hand-written sequences cover full/stall, streaming,
// reset mid-flight and a random mix of stall and push traffic.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  localparam int DEPTH = 4;
  localparam logic [31:0] MEMW = 32'h80FF7F01;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_wb_sel;
  logic [4:0]  in_rd;
  logic [31:0] in_alu;
  logic [31:0] in_pc;
  logic [31:0] in_mem;
  logic [2:0]  in_ld_op;
  logic [1:0]  in_addr_lo;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_wR;
  logic [31:0] rf_wD;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  // Expected result of the entry currently on the inputs.
  logic        drv_we;
  logic [31:0] drv_data;

  int errors = 0;
  int checks = 0;

  wb_stage #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_wb_sel  (in_wb_sel),
    .in_rd      (in_rd),
    .in_alu     (in_alu),
    .in_pc      (in_pc),
    .in_mem     (in_mem),
    .in_ld_op   (in_ld_op),
    .in_addr_lo (in_addr_lo),
    .stall      (stall),
    .rf_we      (rf_we),
    .rf_wR      (rf_wR),
    .rf_wD      (rf_wD)
`ifdef WB_FWD_EN
    ,
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_head;
  exp_t mon_new;
  bit   mon_pop;
  bit   mon_push;

  always @(negedge rst) exp_q.delete();

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      mon_pop  = (exp_q.size() > 0) && !stall;
      mon_push = in_valid && (exp_q.size() < DEPTH);
      mon_new.rd   = in_rd;
      mon_new.data = drv_data;
      mon_new.we   = drv_we;
      if (mon_pop)  mon_head = exp_q.pop_front();
      if (mon_push) exp_q.push_back(mon_new);
      #1;
      if (rst === 1'b1) begin
        if (mon_pop) begin
          check("sb_we", {31'h0, rf_we}, {31'h0, mon_head.we});
          if (mon_head.we) begin
            check("sb_rd",   {27'h0, rf_wR}, {27'h0, mon_head.rd});
            check("sb_data", rf_wD, mon_head.data);
          end
        end else begin
          check("sb_idle_we", {31'h0, rf_we}, 32'h0);
        end
        check("sb_ready", {31'h0, in_ready}, {31'h0, exp_q.size() < DEPTH});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: each call sets inputs for exactly the next rising edge
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] mem;
    logic [2:0]  ld;
    logic [1:0]  lo;
    logic        we;
    logic [31:0] data;
  } vec_t;

  task automatic drive(input vec_t v);
    in_valid   = 1'b1;
    in_wb_sel  = v.sel;
    in_rd      = v.rd;
    in_alu     = v.alu;
    in_pc      = v.pc;
    in_mem     = v.mem;
    in_ld_op   = v.ld;
    in_addr_lo = v.lo;
    drv_we     = v.we;
    drv_data   = v.data;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic vec_t alu_vec(input logic [4:0] rd, input logic [31:0] val);
    vec_t v;
    v = '{2'b00, rd, val, 32'h0, 32'h0, 3'b010, 2'd0, (rd != 5'd0), val};
    return v;
  endfunction

  vec_t vecs[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{2'b00, 5'd5,  32'h12345678, 32'h00000100, 32'h0, 3'b010, 2'd0, 1'b1, 32'h12345678};
    vecs[1]  = '{2'b01, 5'd1,  32'hCAFEF00D, 32'h00000200, MEMW, 3'b000, 2'd1, 1'b1, 32'h0000007F};
    vecs[2]  = '{2'b01, 5'd2,  32'hCAFEF00D, 32'h00000200, MEMW, 3'b000, 2'd2, 1'b1, 32'hFFFFFFFF};
    vecs[3]  = '{2'b01, 5'd3,  32'hCAFEF00D, 32'h00000200, MEMW, 3'b101, 2'd2, 1'b1, 32'h000080FF};
    vecs[4]  = '{2'b01, 5'd4,  32'hCAFEF00D, 32'h00000200, MEMW, 3'b001, 2'd3, 1'b1, 32'hFFFF80FF};
    vecs[5]  = '{2'b01, 5'd6,  32'hCAFEF00D, 32'h00000200, MEMW, 3'b100, 2'd3, 1'b1, 32'h00000080};
    vecs[6]  = '{2'b01, 5'd8,  32'hCAFEF00D, 32'h00000200, MEMW, 3'b001, 2'd0, 1'b1, 32'h00007F01};
    vecs[7]  = '{2'b01, 5'd9,  32'hCAFEF00D, 32'h00000200, MEMW, 3'b010, 2'd2, 1'b1, 32'h80FF7F01};
    vecs[8]  = '{2'b01, 5'd10, 32'hCAFEF00D, 32'h00000200, MEMW, 3'b011, 2'd1, 1'b1, 32'h80FF7F01};
    vecs[9]  = '{2'b01, 5'd11, 32'hCAFEF00D, 32'h00000200, MEMW, 3'b101, 2'd1, 1'b1, 32'h00007F01};
    vecs[10] = '{2'b01, 5'd12, 32'hCAFEF00D, 32'h00000200, MEMW, 3'b000, 2'd0, 1'b1, 32'h00000001};
    vecs[11] = '{2'b10, 5'd3,  32'hCAFEF00D, 32'hFFFFFFFC, MEMW, 3'b010, 2'd0, 1'b1, 32'h00000000};
    vecs[12] = '{2'b10, 5'd13, 32'hCAFEF00D, 32'h00001000, MEMW, 3'b010, 2'd0, 1'b1, 32'h00001004};
    vecs[13] = '{2'b00, 5'd0,  32'hDEADBEEF, 32'h0,        32'h0, 3'b010, 2'd0, 1'b0, 32'hDEADBEEF};
    vecs[14] = '{2'b11, 5'd7,  32'hDEADBEEF, 32'h0,        32'h0, 3'b010, 2'd0, 1'b0, 32'h0};

    rst = 1'b0; stall = 1'b0; in_valid = 1'b0;
    in_wb_sel = 2'b00; in_rd = 5'd0; in_alu = 32'h0; in_pc = 32'h0; in_mem = 32'h0;
    in_ld_op = 3'b010; in_addr_lo = 2'd0; drv_we = 1'b0; drv_data = 32'h0;

    // ---- Reset state -------------------------------------------------------
    #1;
    check("rst_we",    {31'h0, rf_we},    32'h0);
    check("rst_wR",    {27'h0, rf_wR},    32'h0);
    check("rst_wD",    rf_wD,             32'h0);
    check("rst_ready", {31'h0, in_ready}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
    check("ready_after_rst", {31'h0, in_ready}, 32'h1);
    @(negedge clk);

    // ---- Single-entry vectors: rf port one edge after the push edge --------
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      in_valid = 1'b0;
      @(posedge clk); #2;
      check($sformatf("vec%0d_we", i), {31'h0, rf_we}, {31'h0, vecs[i].we});
      if (vecs[i].we) begin
        check($sformatf("vec%0d_rd", i),   {27'h0, rf_wR}, {27'h0, vecs[i].rd});
        check($sformatf("vec%0d_data", i), rf_wD, vecs[i].data);
      end
      @(posedge clk); #2;
      check($sformatf("vec%0d_we_drop", i), {31'h0, rf_we}, 32'h0);
      @(negedge clk);
    end

    // ---- Full under stall, then drain in order ------------------------------
    stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) drive(alu_vec(5'(i + 1), 32'hA0 + 32'(i)));
`ifdef WB_FWD_EN
    check("fwd_valid_full", {31'h0, fwd_valid}, 32'h1);
    check("fwd_rd_full",    {27'h0, fwd_rd},    DEPTH);
    check("fwd_data_full",  fwd_data,           32'hA0 + DEPTH - 1);
`endif
    drive(alu_vec(5'd9, 32'hDEAD0009));   // refused: buffer full
    check("full_ready", {31'h0, in_ready}, 32'h0);
    check("full_stall_we", {31'h0, rf_we}, 32'h0);
    stall = 1'b0;
    idle(1);
    check("ready_after_pop", {31'h0, in_ready}, 32'h1);
    idle(DEPTH + 1);

    // ---- Streaming: push and pop on the same edges --------------------------
    for (int i = 0; i < 6; i++) drive(alu_vec(5'(20 + i), 32'h5000 + 32'(i)));
    check("stream_ready", {31'h0, in_ready}, 32'h1);
    idle(3);

    // ---- Reset mid-flight with entries buffered ----------------------------
    stall = 1'b1;
    drive(alu_vec(5'd10, 32'h111));
    drive(alu_vec(5'd11, 32'h222));
    drive(alu_vec(5'd12, 32'h333));
    stall = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #2;                   // first entry on the rf port now
    rst = 1'b0;
    #1;
    check("midrst_we",    {31'h0, rf_we},    32'h0);
    check("midrst_ready", {31'h0, in_ready}, 32'h0);
    check("midrst_wD",    rf_wD,             32'h0);
`ifdef WB_FWD_EN
    check("midrst_fwd", {31'h0, fwd_valid}, 32'h0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(4);                              // scoreboard expects no writes

    // ---- Random stall/push mix ---------------------------------------------
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        drive(alu_vec(5'($urandom_range(0, 31)), $urandom));
      end else begin
        idle(1);
      end
    end
    stall = 1'b0;
    idle(DEPTH + 2);
    check("final_ready", {31'h0, in_ready}, 32'h1);
    check("final_we",    {31'h0, rf_we},    32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
